nios2_debug_ocimem_arbiter: RTL

Sequences JTAG debug-slave memory commands into the CPU's on-chip debug RAM (OCIMEM) and shares that single-port RAM with the CPU's Avalon debug-slave port. It sits in the sysclk domain after the debug-slave sysclk stage. It decodes the take_action_ocimem_a/b and take_no_action_ocimem_a pulses and the jdo payload, auto-increments the debug address, and returns read data and status on MonDReg, monitor_ready and monitor_error.

---
 rtl/nios2_dbg_pkg.sv | 21 ++
 rtl/nios2_dbg_rr_arb2.sv | 44 ++++
 rtl/nios2_debug_ocimem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared types and jdo field positions for the
// Nios II debug OCIMEM arbiter.
package nios2_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    JTAG_RD
  } state_t;

  typedef enum logic {
    JCMD_WR,
    JCMD_RD
  } jcmd_t;

  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_RDNOW_BIT  = 25;
  localparam int JDO_ERRCLR_BIT = 26;
  localparam int JDO_DATA_LSB   = 3;

endpackage

// File: rtl/nios2_dbg_rr_arb2.sv
// Two-way round-robin arbiter, CPU vs JTAG.
// The last winner yields on a tie.
module nios2_dbg_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req_cpu,
  input  logic req_jtag,
  output logic gnt_cpu,
  output logic gnt_jtag
);

  logic last_jtag_q;
  logic last_jtag_d;

  always_comb begin
    gnt_cpu     = 1'b0;
    gnt_jtag    = 1'b0;
    last_jtag_d = last_jtag_q;
    if (en) begin
      if (req_cpu && req_jtag) begin
        gnt_jtag = !last_jtag_q;
        gnt_cpu  = last_jtag_q;
      end else begin
        gnt_cpu  = req_cpu;
        gnt_jtag = req_jtag;
      end
      if (gnt_jtag) begin
        last_jtag_d = 1'b1;
      end else if (gnt_cpu) begin
        last_jtag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_jtag_q <= 1'b0;
    end else begin
      last_jtag_q <= last_jtag_d;
    end
  end

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// JTAG debug command sequencer sharing the
// single-port OCIMEM with the CPU debug slave.
module nios2_debug_ocimem_arbiter
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  jcmd_t               pcmd_q, pcmd_d;
  logic [DATA_W-1:0]   pdata_q, pdata_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;

  logic                cpu_req;
  logic                cpu_done;
  logic                arb_en;
  logic                gnt_cpu;
  logic                gnt_jtag;
  logic [ADDR_W-1:0]   j_addr;
  logic [DATA_W-1:0]   j_data;
  logic                j_rdnow;
  logic                j_errclr;
  logic                unused_jdo;

  assign j_addr     = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign j_data     = jdo[JDO_DATA_LSB +: DATA_W];
  assign j_rdnow    = jdo[JDO_RDNOW_BIT];
  assign j_errclr   = jdo[JDO_ERRCLR_BIT];
  assign unused_jdo = ^{jdo[2:0], jdo[37:35]};

  assign cpu_req = avs_read | avs_write;
  // No grants while reset is held, so nothing reaches the RAM
  assign arb_en  = (state_q == IDLE) && reset_n;

  nios2_dbg_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (arb_en),
    .req_cpu  (cpu_req),
    .req_jtag (pend_q),
    .gnt_cpu  (gnt_cpu),
    .gnt_jtag (gnt_jtag)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pcmd_d       = pcmd_q;
    pdata_d      = pdata_q;
    jaddr_d      = jaddr_q;
    mon_d        = mon_q;
    rdy_d        = rdy_q;
    err_d        = err_q;
    ram_addr     = jaddr_q;
    ram_wren     = 1'b0;
    ram_wdata    = pdata_q;
    avs_readdata = '0;
    cpu_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_cpu) begin
          ram_addr = avs_address;
          if (avs_write) begin
            ram_wren  = 1'b1;
            ram_wdata = avs_writedata;
            cpu_done  = 1'b1;
          end else begin
            state_d = CPU_RD;
          end
        end else if (gnt_jtag) begin
          if (pcmd_q == JCMD_WR) begin
            ram_wren = 1'b1;
            pend_d   = 1'b0;
            jaddr_d  = jaddr_q + 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d = JTAG_RD;
          end
        end
      end
      CPU_RD: begin
        ram_addr     = avs_address;
        avs_readdata = ram_rdata;
        cpu_done     = 1'b1;
        state_d      = IDLE;
      end
      JTAG_RD: begin
        mon_d   = ram_rdata;
        jaddr_d = jaddr_q + 1'b1;
        pend_d  = 1'b0;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Take pulses override the sequencer's own updates
    if (take_action_ocimem_a) begin
      jaddr_d = j_addr;
      pend_d  = 1'b0;
      if (j_errclr) begin
        err_d = 1'b0;
      end
      if (j_rdnow) begin
        pend_d = 1'b1;
        pcmd_d = JCMD_RD;
        rdy_d  = 1'b0;
      end else begin
        rdy_d = 1'b1;
      end
    end else if (take_action_ocimem_b ||
                 take_no_action_ocimem_a) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        pcmd_d  = take_action_ocimem_b ? JCMD_WR : JCMD_RD;
        pdata_d = j_data;
        rdy_d   = 1'b0;
      end
    end
  end

  assign avs_waitrequest = cpu_req & ~cpu_done;
  assign MonDReg         = mon_q;
  assign monitor_ready   = rdy_q;
  assign monitor_error   = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      pcmd_q  <= JCMD_WR;
      pdata_q <= '0;
      jaddr_q <= '0;
      mon_q   <= '0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pcmd_q  <= pcmd_d;
      pdata_q <= pdata_d;
      jaddr_q <= jaddr_d;
      mon_q   <= mon_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

endmodule
